// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared SISC arbiter state, owner codes and default widths
package sisc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_t;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_DM = 1'b1;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/sisc_mem_arb.sv
// rtl/sisc_mem_arb.sv - fetch/data arbiter for the single-port unified SISC memory
// Data wins contention unless fetch has already lost MAX_WAIT times in a row.
module sisc_mem_arb
   import sisc_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MEM_LAT  = 2,
   parameter int MAX_WAIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ack,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int STV_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

   generate
      if (MEM_LAT < 1) begin : g_bad_lat
         $error("sisc_mem_arb: MEM_LAT must be >= 1");
      end
   endgenerate

   arb_state_t       state;
   logic [CNT_W-1:0] lat_cnt;
   logic [STV_W-1:0] starve;
   logic             grant_dm;
   logic             grant_if;

   always_comb begin
      grant_dm = dm_req && (!if_req || (starve != STV_W'(MAX_WAIT)));
      grant_if = if_req && !grant_dm;
   end

   // Acks are the only outputs decoded from state rather than registered.
   assign if_ack = (state == DONE) && (owner == OWN_IF);
   assign dm_ack = (state == DONE) && (owner == OWN_DM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         lat_cnt   <= '0;
         starve    <= '0;
         owner     <= OWN_IF;
         busy      <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_dm || grant_if) begin
                  owner    <= grant_dm ? OWN_DM : OWN_IF;
                  mem_addr <= grant_dm ? dm_addr : if_addr;
                  mem_we   <= grant_dm && dm_we;
                  if (grant_dm)
                     mem_wdata <= dm_wdata;
                  mem_en  <= 1'b1;
                  busy    <= 1'b1;
                  lat_cnt <= CNT_W'(MEM_LAT - 1);
                  state   <= ACCESS;
                  if (grant_if)
                     starve <= '0;
                  else if (if_req && (starve != STV_W'(MAX_WAIT)))
                     starve <= starve + 1'b1;
               end
            end
            ACCESS: begin
               if (lat_cnt == '0) begin
                  if (owner == OWN_IF)
                     if_rdata <= mem_rdata;
                  else if (!mem_we)
                     dm_rdata <= mem_rdata;
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
                  state  <= DONE;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy   <= 1'b0;
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sisc_mem_arb.sv
// tb/tb_sisc_mem_arb.sv - directed self-checking bench for sisc_mem_arb
module tb_sisc_mem_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [15:0] if_addr = '0;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [15:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        owner;

   int n_checks = 0;
   int n_fail = 0;
   int excl_err = 0;
   int we_err = 0;
   logic [31:0] st42 = '0;

   sisc_mem_arb #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(2), .MAX_WAIT(3)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   // Memory model: two ROM words plus one writable word at 0x42.
   always_comb begin
      case (mem_addr)
         16'h0010: mem_rdata = 32'hDEADBEEF;
         16'h0020: mem_rdata = 32'hCAFEF00D;
         16'h0042: mem_rdata = st42;
         default:  mem_rdata = 32'h0;
      endcase
   end

   always @(posedge clk)
      if (mem_en && mem_we && mem_addr == 16'h0042) st42 <= mem_wdata;

   always @(negedge clk) begin
      if (if_ack && dm_ack) excl_err++;
      if (mem_we && owner == 1'b0) we_err++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] order[$];
      string exp_ord;
      int acks;
      bit ok;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("idle_busy", busy, 0);
      end
      check("idle_outs", {mem_en, mem_we, if_ack, dm_ack, owner}, 0);
      check("idle_addr", mem_addr, 0);
      check("idle_wdata", mem_wdata, 0);
      check("idle_if_rdata", if_rdata, 0);
      check("idle_dm_rdata", dm_rdata, 0);

      // Single fetch
      if_req = 1'b1; if_addr = 16'h0010;
      tick();
      check("f_c1_en", {mem_en, mem_we, busy, owner, if_ack}, 5'b10100);
      check("f_c1_addr", mem_addr, 16'h0010);
      tick();
      check("f_c2_en", {mem_en, mem_we, if_ack}, 3'b100);
      tick();
      check("f_c3_ack", {if_ack, dm_ack, mem_en}, 3'b100);
      check("f_c3_rdata", if_rdata, 32'hDEADBEEF);
      if_req = 1'b0;
      tick();
      check("f_c4_idle", {if_ack, busy}, 0);
      check("f_c4_hold", if_rdata, 32'hDEADBEEF);

      // Store then load of 0x42
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0042; dm_wdata = 32'h12345678;
      tick();
      check("s_c1", {mem_en, mem_we, owner}, 3'b111);
      check("s_c1_wdata", mem_wdata, 32'h12345678);
      tick();
      check("s_c2_we", mem_we, 1);
      tick();
      check("s_c3_ack", {dm_ack, if_ack}, 2'b10);
      check("s_c3_rdata", dm_rdata, 0);
      dm_req = 1'b0;
      tick();
      check("s_mem", st42, 32'h12345678);
      dm_req = 1'b1; dm_we = 1'b0;
      repeat (3) tick();
      check("l_ack", dm_ack, 1);
      check("l_rdata", dm_rdata, 32'h12345678);
      dm_req = 1'b0;
      tick();

      // Contention with both requesters held high
      if_req = 1'b1; if_addr = 16'h0010;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0020;
      for (int c = 0; c < 60 && order.size() < 8; c++) begin
         tick();
         if (dm_ack) order.push_back("D");
         if (if_ack) order.push_back("I");
         if (order.size() == 8) begin
            if_req = 1'b0; dm_req = 1'b0;
         end
      end
      if_req = 1'b0; dm_req = 1'b0;
      check("cont_count", order.size(), 8);
      exp_ord = "DDDIDDDI";
      for (int i = 0; i < order.size() && i < 8; i++)
         check($sformatf("cont_grant%0d", i), order[i], exp_ord[i]);
      tick();

      // Reset during second ACCESS cycle
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0042;
      tick();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_async", {mem_en, busy}, 0);
      check("rst_dm_rdata", dm_rdata, 0);
      acks = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (dm_ack) acks++;
      end
      rst = 1'b0;
      check("rst_no_ack", acks, 0);
      ok = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (dm_ack) begin
            ok = 1'b1;
            break;
         end
      end
      check("rst_reissue", ok, 1);
      check("rst_reissue_data", dm_rdata, 32'h12345678);
      dm_req = 1'b0;
      tick();

      // Data request arriving during a fetch
      if_req = 1'b1; if_addr = 16'h0010;
      tick();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0020;
      tick();
      check("b_c2_owner", {mem_en, owner}, 2'b10);
      check("b_c2_addr", mem_addr, 16'h0010);
      tick();
      check("b_c3_ack", {if_ack, dm_ack}, 2'b10);
      if_req = 1'b0;
      tick();
      check("b_c4_idle", {busy, mem_en}, 0);
      tick();
      check("b_c5_start", {mem_en, owner}, 2'b11);
      check("b_c5_addr", mem_addr, 16'h0020);
      repeat (2) tick();
      check("b_c7_ack", {dm_ack, if_ack}, 2'b10);
      check("b_c7_rdata", dm_rdata, 32'hCAFEF00D);
      dm_req = 1'b0;
      tick();

      check("ack_exclusive", excl_err, 0);
      check("we_owner", we_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
